// File: rtl/pwm_fifo_stream_mc.sv
// rtl/pwm_fifo_stream_mc.sv - multichannel PWM sample FIFO, tick-paced frame emitter with underrun tracking
// Optional feature macro: PWM_FIFO_HOLD_LAST_EN (repeat last real frame on underrun instead of zeros).
module pwm_fifo_stream_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0]      in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                tick,
  input  logic                                flush,
  output logic [DATA_WIDTH*CHANNELS-1:0]      out_data,
  output logic                                out_valid,
  output logic [$clog2(DEPTH):0]              level,
  output logic                                underrun,
  output logic [15:0]                         underrun_cnt
);

  localparam int W  = DATA_WIDTH * CHANNELS;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q;
  logic            b_tick_q;
  logic [W-1:0]    frame_q, frame_d;
  logic            urun_q;
  logic [15:0]     cnt_q;
  logic [W-1:0]    urun_frame;
  logic            service, do_push, do_pop, is_urun;

  // flush gates the registered ready so nothing lands in the cycle it is being discarded
  assign in_ready = ready_q & ~flush;
  assign do_push  = in_valid & in_ready;

  // a tick that arrived during EMIT is parked in pend_q and serviced on return to IDLE
  assign service  = (state_q == S_IDLE) & (b_tick_q | pend_q);
  assign do_pop   = service & ~flush & (level_q != '0);
  assign is_urun  = service & ~do_pop;

  assign level_d  = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
  assign frame_d  = do_pop ? mem_q[rd_ptr_q] : urun_frame;

`ifdef PWM_FIFO_HOLD_LAST_EN
  logic [W-1:0] last_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      last_q <= '0;
    end else if (do_pop) begin
      last_q <= mem_q[rd_ptr_q];
    end
  end

  assign urun_frame = flush ? '0 : last_q;
`else
  assign urun_frame = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (b_tick_q || pend_q) begin
          state_d = S_EMIT;
          pend_d  = 1'b0;
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
        if (b_tick_q) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_EMIT);
    out_data  = out_valid ? frame_q : '0;
    underrun  = out_valid & urun_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      b_tick_q <= 1'b0;
      frame_q  <= '0;
      urun_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      b_tick_q <= tick;
      level_q  <= level_d;
      ready_q  <= (level_d != LW'(DEPTH));
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (service) begin
        frame_q <= frame_d;
        urun_q  <= is_urun;
      end
      if (is_urun && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign level        = level_q;
  assign underrun_cnt = cnt_q;

endmodule
